// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_pipe
// Description : Registered, handshaked instruction-decode control stage for
//               the 16-bit WISC datapath. Decodes each accepted instruction
//               into a control bundle held in an output register with
//               valid/ready flow control, inserts load-use bubbles, honours
//               flush, and walks HALT / illegal opcodes through a drain
//               sequence into a halted state.
// Options     : LOAD_USE_INTERLOCK_EN - when defined, a load-use tracker and
//               one-slot bubble insertion are built; when undefined the
//               bubble is tied low and dependent loads issue back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_pipe #(
  parameter int ALU_OP_W     = 4,
  parameter int REG_W        = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_instr,
  output logic                reg_wrt,
  output logic                mem_wrt,
  output logic                mem_rd,
  output logic [1:0]          reg_src,
  output logic [1:0]          b_src,
  output logic                zero_ext,
  output logic [ALU_OP_W-1:0] alu_opr,
  output logic [2:0]          branch,
  output logic                jmp,
  output logic                jmp_reg,
  output logic [REG_W-1:0]    dst_reg,
  output logic                halted,
  output logic                err
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [ALU_OP_W-1:0] c_alu_add   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] c_alu_rol   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] c_alu_seq   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] c_alu_passb = ALU_OP_W'(12);
  localparam logic [ALU_OP_W-1:0] c_alu_slbi  = ALU_OP_W'(13);

  localparam logic [1:0] c_src_pc   = 2'b00;
  localparam logic [1:0] c_src_mem  = 2'b01;
  localparam logic [1:0] c_src_alu  = 2'b10;
  localparam logic [1:0] c_src_flag = 2'b11;

  localparam logic [1:0] c_b_rt    = 2'b00;
  localparam logic [1:0] c_b_imm   = 2'b01;
  localparam logic [1:0] c_b_imm8  = 2'b10;

  // Drain counter runs 0 .. DRAIN_CYCLES-1 while in S_DRAIN.
  localparam int                 c_cnt_w    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DRAIN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_drain_cnt;

  logic [4:0]           w_op;
  logic                 w_reg_wrt;
  logic                 w_mem_wrt;
  logic                 w_mem_rd;
  logic [1:0]           w_reg_src;
  logic [1:0]           w_b_src;
  logic                 w_zero_ext;
  logic [ALU_OP_W-1:0]  w_alu;
  logic [2:0]           w_branch;
  logic                 w_jmp;
  logic                 w_jmp_reg;
  logic [REG_W-1:0]     w_dst;
  logic                 w_halt;
  logic                 w_illegal;

  logic                 w_run;
  logic                 w_slot_free;
  logic                 w_bubble;
  logic                 w_accept;

  assign w_op = instr[15:11];

  // --------------------------------------------------------------------------
  // Instruction decode; any opcode not listed falls into the illegal path and
  // produces an all-zero (NOP) bundle.
  // --------------------------------------------------------------------------
  // Combinational decode of the presented instruction into a control bundle
  always_comb begin
    w_reg_wrt  = 1'b0;
    w_mem_wrt  = 1'b0;
    w_mem_rd   = 1'b0;
    w_reg_src  = c_src_pc;
    w_b_src    = c_b_rt;
    w_zero_ext = 1'b0;
    w_alu      = c_alu_add;
    w_branch   = 3'b000;
    w_jmp      = 1'b0;
    w_jmp_reg  = 1'b0;
    w_dst      = '0;
    w_halt     = 1'b0;
    w_illegal  = 1'b0;
    casez (w_op)
      // ADDI / SUBI / XORI / ANDNI: logical ops (instr[12]=1) zero-extend
      5'b010??: begin
        w_reg_wrt  = 1'b1;
        w_reg_src  = c_src_alu;
        w_b_src    = c_b_imm;
        w_zero_ext = instr[12];
        w_alu      = c_alu_add + ALU_OP_W'(instr[12:11]);
        w_dst      = instr[7:5];
      end
      // ROLI / SLLI / RORI / SRLI
      5'b101??: begin
        w_reg_wrt  = 1'b1;
        w_reg_src  = c_src_alu;
        w_b_src    = c_b_imm;
        w_zero_ext = 1'b1;
        w_alu      = c_alu_rol + ALU_OP_W'(instr[12:11]);
        w_dst      = instr[7:5];
      end
      // ST: address = Rs + imm
      5'b10000: begin
        w_mem_wrt = 1'b1;
        w_b_src   = c_b_imm;
        w_alu     = c_alu_add;
      end
      // LD
      5'b10001: begin
        w_mem_rd  = 1'b1;
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_mem;
        w_b_src   = c_b_imm;
        w_alu     = c_alu_add;
        w_dst     = instr[7:5];
      end
      // SLBI
      5'b10010: begin
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_alu;
        w_b_src   = c_b_imm8;
        w_alu     = c_alu_slbi;
        w_dst     = instr[10:8];
      end
      // STU: store and write the updated address back into Rs
      5'b10011: begin
        w_mem_wrt = 1'b1;
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_alu;
        w_b_src   = c_b_imm;
        w_alu     = c_alu_add;
        w_dst     = instr[10:8];
      end
      // LBI
      5'b11000: begin
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_alu;
        w_b_src   = c_b_imm8;
        w_alu     = c_alu_passb;
        w_dst     = instr[10:8];
      end
      // R-format shifts/rotates
      5'b11010: begin
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_alu;
        w_alu     = c_alu_rol + ALU_OP_W'(instr[1:0]);
        w_dst     = instr[4:2];
      end
      // R-format arithmetic/logic
      5'b11011: begin
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_alu;
        w_alu     = c_alu_add + ALU_OP_W'(instr[1:0]);
        w_dst     = instr[4:2];
      end
      // SEQ / SLT / SLE / SCO write the ALU flag
      5'b111??: begin
        w_reg_wrt = 1'b1;
        w_reg_src = c_src_flag;
        w_alu     = c_alu_seq + ALU_OP_W'(instr[12:11]);
        w_dst     = instr[4:2];
      end
      // Conditional branches
      5'b011??: begin
        w_branch = {1'b1, instr[12:11]};
      end
      // J / JR / JAL / JALR: instr[11] selects register target, instr[12] links
      5'b001??: begin
        w_jmp     = 1'b1;
        w_jmp_reg = instr[11];
        if (instr[12]) begin
          w_reg_wrt = 1'b1;
          w_reg_src = c_src_pc;
          w_dst     = {REG_W{1'b1}};
        end
      end
      5'b00001: begin
        // NOP: all-zero bundle
      end
      5'b00000: begin
        w_halt = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  assign w_run       = (r_state == S_RUN);
  assign w_slot_free = !out_valid || out_ready;
  assign in_ready    = w_run && !flush && !w_bubble && w_slot_free;
  assign w_accept    = in_valid && in_ready;

`ifdef LOAD_USE_INTERLOCK_EN
  // --------------------------------------------------------------------------
  // Load-use tracker: remembers the destination of the last LD placed in the
  // output register so the next consumer of that register is held back one
  // slot. J and JAL carry no Rs; Rt is read only by R-format, ST and STU.
  // --------------------------------------------------------------------------
  logic             r_trk_valid;
  logic [2:0]       r_trk_dst;
  logic             w_uses_rs;
  logic             w_uses_rt;
  logic             w_is_ld;

  assign w_uses_rs = (w_op != 5'b00100) && (w_op != 5'b00110);
  assign w_uses_rt = (w_op == 5'b11010) || (w_op == 5'b11011) ||
                     (w_op[4:2] == 3'b111) ||
                     (w_op == 5'b10000) || (w_op == 5'b10011);
  assign w_is_ld   = (w_op == 5'b10001);

  assign w_bubble  = in_valid && r_trk_valid &&
                     ((w_uses_rs && (instr[10:8] == r_trk_dst)) ||
                      (w_uses_rt && (instr[7:5]  == r_trk_dst)));

  // Tracker follows each bundle loaded; flush and the bubble slot clear it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trk_valid <= 1'b0;
      r_trk_dst   <= 3'd0;
    end else if (w_run && flush) begin
      r_trk_valid <= 1'b0;
    end else if (w_run && w_slot_free) begin
      if (w_accept) begin
        r_trk_valid <= w_is_ld;
        r_trk_dst   <= instr[7:5];
      end else if (w_bubble) begin
        r_trk_valid <= 1'b0;
      end
    end
  end
`else
  assign w_bubble = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output register. A held bundle stays frozen while out_ready is low; when
  // the slot frees up without a new acceptance the bundle is zeroed so no
  // stale control leaks out alongside out_valid=0.
  // --------------------------------------------------------------------------
  // Load, hold or clear the registered control bundle
  always_ff @(posedge clk) begin
    if (rst || (w_run && flush) || (w_slot_free && !w_accept)) begin
      out_valid <= 1'b0;
      out_instr <= 16'h0000;
      reg_wrt   <= 1'b0;
      mem_wrt   <= 1'b0;
      mem_rd    <= 1'b0;
      reg_src   <= 2'b00;
      b_src     <= 2'b00;
      zero_ext  <= 1'b0;
      alu_opr   <= '0;
      branch    <= 3'b000;
      jmp       <= 1'b0;
      jmp_reg   <= 1'b0;
      dst_reg   <= '0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_instr <= instr;
      reg_wrt   <= w_reg_wrt;
      mem_wrt   <= w_mem_wrt;
      mem_rd    <= w_mem_rd;
      reg_src   <= w_reg_src;
      b_src     <= w_b_src;
      zero_ext  <= w_zero_ext;
      alu_opr   <= w_alu;
      branch    <= w_branch;
      jmp       <= w_jmp;
      jmp_reg   <= w_jmp_reg;
      dst_reg   <= w_dst;
    end
  end

  // --------------------------------------------------------------------------
  // Run / drain / halted sequencing
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_accept && (w_halt || w_illegal)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == c_cnt_last) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // Count bubble cycles spent in S_DRAIN
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_DRAIN)) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + c_cnt_one;
    end
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      err <= 1'b1;
    end
  end

  assign halted = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_pipe
// Description : Self-checking bench for decode_ctrl_pipe. Directed scenarios
//               followed by randomized traffic, every cycle compared against
//               a behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_pipe;

`ifdef LOAD_USE_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif
  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic        reg_wrt, mem_wrt, mem_rd, zero_ext, jmp, jmp_reg, halted, err;
  logic [1:0]  reg_src, b_src;
  logic [3:0]  alu_opr;
  logic [2:0]  branch;
  logic [2:0]  dst_reg;
  logic [19:0] dut_bundle;

  int checks   = 0;
  int failures = 0;

  decode_ctrl_pipe #(
    .ALU_OP_W     (4),
    .REG_W        (3),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .reg_wrt   (reg_wrt),
    .mem_wrt   (mem_wrt),
    .mem_rd    (mem_rd),
    .reg_src   (reg_src),
    .b_src     (b_src),
    .zero_ext  (zero_ext),
    .alu_opr   (alu_opr),
    .branch    (branch),
    .jmp       (jmp),
    .jmp_reg   (jmp_reg),
    .dst_reg   (dst_reg),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign dut_bundle = {reg_wrt, mem_wrt, mem_rd, reg_src, b_src, zero_ext,
                       alu_opr, branch, jmp, jmp_reg, dst_reg};

  // ---------------------------------------------------------------- model
  logic        m_ov;
  logic [15:0] m_instr;
  logic        m_ld_valid;
  logic [2:0]  m_ld_dst;
  int          m_drain;
  logic        m_halted;
  logic        m_err;

  function automatic void m_reset();
    m_ov = 1'b0; m_instr = 16'h0; m_ld_valid = 1'b0; m_ld_dst = 3'd0;
    m_drain = 0; m_halted = 1'b0; m_err = 1'b0;
  endfunction

  function automatic bit is_legal(input int op);
    return !(op == 2 || op == 3 || op == 25);
  endfunction

  function automatic bit uses_rs(input int op);
    return !(op == 4 || op == 6);
  endfunction

  function automatic bit uses_rt(input int op);
    return (op == 26 || op == 27 || op >= 28 || op == 16 || op == 19);
  endfunction

  // Expected control bundle straight from the opcode table
  function automatic logic [19:0] exp_bundle(input logic [15:0] i);
    int op; int alu;
    logic rw, mw, mr, ze, j, jr;
    logic [1:0] rs, bs;
    logic [2:0] br, dst;
    logic [3:0] alu_v;
    op = int'(i[15:11]);
    rw = 0; mw = 0; mr = 0; ze = 0; j = 0; jr = 0;
    rs = 2'd0; bs = 2'd0; br = 3'd0; dst = 3'd0; alu = 0;
    if (op >= 8 && op <= 11) begin
      rw = 1; rs = 2; bs = 1; ze = (op >= 10); alu = op - 8; dst = i[7:5];
    end else if (op >= 20 && op <= 23) begin
      rw = 1; rs = 2; bs = 1; ze = 1; alu = op - 16; dst = i[7:5];
    end else if (op == 16) begin
      mw = 1; bs = 1;
    end else if (op == 17) begin
      mr = 1; rw = 1; rs = 1; bs = 1; dst = i[7:5];
    end else if (op == 19) begin
      mw = 1; rw = 1; rs = 2; bs = 1; dst = i[10:8];
    end else if (op == 27) begin
      rw = 1; rs = 2; alu = int'(i[1:0]); dst = i[4:2];
    end else if (op == 26) begin
      rw = 1; rs = 2; alu = 4 + int'(i[1:0]); dst = i[4:2];
    end else if (op >= 28) begin
      rw = 1; rs = 3; alu = op - 20; dst = i[4:2];
    end else if (op >= 12 && op <= 15) begin
      br = {1'b1, i[12:11]};
    end else if (op == 24) begin
      rw = 1; rs = 2; bs = 2; alu = 12; dst = i[10:8];
    end else if (op == 18) begin
      rw = 1; rs = 2; bs = 2; alu = 13; dst = i[10:8];
    end else if (op >= 4 && op <= 7) begin
      j = 1; jr = (op == 5 || op == 7);
      if (op >= 6) begin rw = 1; rs = 0; dst = 3'd7; end
    end
    alu_v = alu[3:0];
    return {rw, mw, mr, rs, bs, ze, alu_v, br, j, jr, dst};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model
  task automatic step(input logic r, input logic iv, input logic [15:0] ins,
                      input logic fl, input logic ordy);
    int op; bit e_run, e_bub, e_rdy, acc;
    @(negedge clk);
    rst = r; in_valid = iv; instr = ins; flush = fl; out_ready = ordy;
    #1;
    op    = int'(ins[15:11]);
    e_run = !m_halted && (m_drain == 0);
    e_bub = INTERLOCK && iv && m_ld_valid &&
            ((uses_rs(op) && ins[10:8] == m_ld_dst) || (uses_rt(op) && ins[7:5] == m_ld_dst));
    e_rdy = e_run && !fl && !e_bub && (!m_ov || ordy);
    check("in_ready", 32'(in_ready), 32'(e_rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("halted", 32'(halted), 32'(m_halted));
    check("err", 32'(err), 32'(m_err));
    if (m_ov) begin
      check("bundle", 32'(dut_bundle), 32'(exp_bundle(m_instr)));
      check("out_instr", 32'(out_instr), 32'(m_instr));
    end
    acc = iv && e_rdy;
    if (r) begin
      m_reset();
    end else if (e_run) begin
      if (fl) begin
        m_ov = 0; m_ld_valid = 0;
      end else if (!m_ov || ordy) begin
        if (acc) begin
          m_ov = 1; m_instr = ins;
          m_ld_valid = (op == 17); m_ld_dst = ins[7:5];
          if (op == 0 || !is_legal(op)) begin
            m_drain = DRAIN;
            if (op != 0) m_err = 1;
          end
        end else begin
          m_ov = 0;
          if (e_bub) m_ld_valid = 0;
        end
      end
    end else begin
      if (ordy) m_ov = 0;
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end
    end
  endtask

  int legal_ops [28] = '{1,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18,19,20,21,22,23,24,26,27,28,29,30,31};
  int bad_ops   [4]  = '{0,2,3,25};

  initial begin
    int gap;
    logic [15:0] ri;
    logic riv, rfl, rrdy, rr;

    rst = 1'b1; in_valid = 1'b0; instr = 16'h0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    m_reset();

    // Reset state
    step(0, 0, 16'h0, 0, 1);
    check("rst_bundle", 32'(dut_bundle), 32'h0);
    check("rst_out_instr", 32'(out_instr), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // ADD r3 = r1 + r4
    step(0, 1, 16'hD98C, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    check("add_valid", 32'(out_valid), 32'h1);
    check("add_alu", 32'(alu_opr), 32'h0);
    check("add_dst", 32'(dst_reg), 32'h3);
    check("add_regwrt", 32'(reg_wrt), 32'h1);
    check("add_bsrc", 32'(b_src), 32'h0);

    // LD r1 then dependent ADD
    step(0, 1, 16'h8A20, 0, 1);
    gap = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 16'hD98C, 0, 1);
      if (in_ready) break;
      gap++;
    end
    check("ld_use_gap", 32'(gap), INTERLOCK ? 32'h1 : 32'h0);

    // JAL held under back-pressure
    step(0, 1, 16'h3004, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 16'hD98C, 0, 0);
      check("jal_valid", 32'(out_valid), 32'h1);
      check("jal_dst", 32'(dst_reg), 32'h7);
      check("jal_regsrc", 32'(reg_src), 32'h0);
      check("jal_jmp", 32'(jmp), 32'h1);
      check("jal_in_ready", 32'(in_ready), 32'h0);
    end
    step(0, 0, 16'h0, 0, 1);

    // Flush over a held LD bundle with a dependent instruction waiting
    step(0, 1, 16'h8A20, 0, 1);
    step(0, 1, 16'hD98C, 1, 0);
    check("flush_in_ready", 32'(in_ready), 32'h0);
    step(0, 1, 16'hD98C, 0, 1);
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_trk_clear", 32'(in_ready), 32'h1);
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 1);

    // HALT sequencing
    step(0, 1, 16'h0000, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 16'hD98C, 0, 1);
      check("halt_in_ready", 32'(in_ready), 32'h0);
      if (k == 1) check("halt_nop_valid", 32'(out_valid), 32'h1);
      if (k >= 2) check("halt_no_valid", 32'(out_valid), 32'h0);
      if (k == 4) check("halt_early", 32'(halted), 32'h0);
      if (k == 5) check("halt_rise", 32'(halted), 32'h1);
    end

    // Illegal opcode, then reset clears everything
    step(1, 0, 16'h0, 0, 1);
    step(0, 1, 16'h1000, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    check("ill_err", 32'(err), 32'h1);
    for (int k = 2; k <= 5; k++) step(0, 0, 16'h0, 0, 1);
    check("ill_halted", 32'(halted), 32'h1);
    check("ill_err_sticky", 32'(err), 32'h1);
    step(1, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    check("rst_err", 32'(err), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // Reset in the middle of draining
    step(0, 1, 16'h0000, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 0, 1);
    step(0, 1, 16'hD98C, 0, 1);
    check("mid_drain_rst", 32'(in_ready), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 99) < 2)
        ri[15:11] = 5'(bad_ops[$urandom_range(0, 3)]);
      else
        ri[15:11] = 5'(legal_ops[$urandom_range(0, 27)]);
      ri[10:8] = 3'($urandom_range(0, 3));
      ri[7:5]  = 3'($urandom_range(0, 3));
      ri[4:2]  = 3'($urandom_range(0, 3));
      riv  = ($urandom_range(0, 3) != 0);
      rfl  = ($urandom_range(0, 19) == 0);
      rrdy = ($urandom_range(0, 3) != 0);
      rr   = m_halted && ($urandom_range(0, 1) == 1);
      step(rr, rr ? 1'b0 : riv, ri, rfl, rrdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
